fsm: RTL and testbench

//  Tail-light sequencer for a vehicle turn indicator (three lamps per side).

---
 rtl/fsm.sv | 145 ++++++++++++++
 tb/tb_fsm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fsm.sv
// Turn-indicator tail-light sequencer: three-lamp sweep per side, lamps decoded from registered state.
// Optional hazard mode (both stalks high from IDLE) is built when HAZARD_EN is defined.
module fsm #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  output logic L1,
  output logic L2,
  output logic L3,
  output logic R1,
  output logic R2,
  output logic R3
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LA      = 4'd1,
    LB      = 4'd2,
    LC      = 4'd3,
    RA      = 4'd4,
    RB      = 4'd5,
    RC      = 4'd6
`ifdef HAZARD_EN
    ,
    HAZ_ON  = 4'd7,
    HAZ_OFF = 4'd8
`endif
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  state_t          seq_next_s;
  logic [CW-1:0]   hold_cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            timed_s;
  logic [5:0]      lamps_r;

  // Lamp pattern {L1,L2,L3,R1,R2,R3} for a state; unknown encodings stay dark.
  function automatic logic [5:0] lamp_decode(input state_t s);
    logic [5:0] v;
    case (s)
      LA:      v = 6'b100_000;
      LB:      v = 6'b110_000;
      LC:      v = 6'b111_000;
      RA:      v = 6'b000_100;
      RB:      v = 6'b000_110;
      RC:      v = 6'b000_111;
`ifdef HAZARD_EN
      HAZ_ON:  v = 6'b111_111;
`endif
      default: v = 6'b000_000;
    endcase
    return v;
  endfunction

  // Successor of each state, and whether that state dwells HOLD_CYCLES before moving on.
  always_comb begin
    seq_next_s = IDLE;
    timed_s    = 1'b1;
    case (state_r)
      IDLE: begin
        timed_s = 1'b0;
        if (left) begin
`ifdef HAZARD_EN
          if (right) begin
            seq_next_s = HAZ_ON;
          end else begin
            seq_next_s = LA;
          end
`else
          seq_next_s = LA;
`endif
        end else if (right) begin
          seq_next_s = RA;
        end else begin
          seq_next_s = IDLE;
        end
      end
      LA: seq_next_s = LB;
      LB: seq_next_s = LC;
      LC: seq_next_s = IDLE;
      RA: seq_next_s = RB;
      RB: seq_next_s = RC;
      RC: seq_next_s = IDLE;
`ifdef HAZARD_EN
      HAZ_ON: seq_next_s = HAZ_OFF;
      HAZ_OFF: begin
        // Blink continues straight back to HAZ_ON while both requests persist.
        if (left && right) begin
          seq_next_s = HAZ_ON;
        end else begin
          seq_next_s = IDLE;
        end
      end
`endif
      default: begin
        timed_s    = 1'b0;
        seq_next_s = IDLE;
      end
    endcase
  end

  // Apply the hold counter: timed states advance only after their last hold cycle.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = hold_cnt_r;
    if (!timed_s) begin
      state_next_s = seq_next_s;
      cnt_next_s   = {CW{1'b0}};
    end else if (hold_cnt_r == HOLD_LAST) begin
      state_next_s = seq_next_s;
      cnt_next_s   = {CW{1'b0}};
    end else begin
      state_next_s = state_r;
      cnt_next_s   = hold_cnt_r + CW'(1);
    end
  end

  // State, hold counter and lamp registers; lamps track the decode of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= {CW{1'b0}};
      lamps_r    <= 6'b000_000;
    end else begin
      state_r    <= state_next_s;
      hold_cnt_r <= cnt_next_s;
      lamps_r    <= lamp_decode(state_next_s);
    end
  end

  assign L1 = lamps_r[5];
  assign L2 = lamps_r[4];
  assign L3 = lamps_r[3];
  assign R1 = lamps_r[2];
  assign R2 = lamps_r[1];
  assign R3 = lamps_r[0];

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for the tail-light sequencer: stimulus pushes expected lamps, a monitor pops and compares.
`timescale 1ns/1ps
module tb_fsm;

  logic clk;
  logic reset;
  logic left;
  logic right;
  logic L1, L2, L3, R1, R2, R3;

  int total;
  int bad;
  int step_no;

  typedef struct {
    logic [5:0] lamps;
    int         id;
  } exp_t;

  exp_t exp_q[$];

  fsm #(.HOLD_CYCLES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .left  (left),
    .right (right),
    .L1    (L1),
    .L2    (L2),
    .L3    (L3),
    .R1    (R1),
    .R2    (R2),
    .R3    (R3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] lamps_now();
    return {L1, L2, L3, R1, R2, R3};
  endfunction

  task automatic check(input string name, input int id, input logic [5:0] got, input logic [5:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s step=%0d got=%b want=%b at %0t", name, id, got, want, $time);
    end
  endtask

  // Drive inputs for the next rising edge and queue the lamps expected just after it.
  task automatic step(input logic l, input logic r, input logic [5:0] want);
    exp_t e;
    @(negedge clk);
    left  = l;
    right = r;
    step_no = step_no + 1;
    e.lamps = want;
    e.id    = step_no;
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("lamps", e.id, lamps_now(), e.lamps);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    step_no = 0;
    reset   = 1'b1;
    left    = 1'b0;
    right   = 1'b0;

    // 1: reset held over several edges, released at 41 ns
    #1;
    check("reset_async", 0, lamps_now(), 6'b000_000);
    step(1'b0, 1'b0, 6'b000_000);
    step(1'b0, 1'b0, 6'b000_000);
    step(1'b0, 1'b0, 6'b000_000);
    #11;
    reset = 1'b0;
    step(1'b0, 1'b0, 6'b000_000);

    // 2: right for two edges, sweep completes after release
    step(1'b0, 1'b1, 6'b000_100);
    step(1'b0, 1'b1, 6'b000_110);
    step(1'b0, 1'b0, 6'b000_111);
    step(1'b0, 1'b0, 6'b000_000);

    // 3: left held for eight edges
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 6'b100_000);
      step(1'b1, 1'b0, 6'b110_000);
      step(1'b1, 1'b0, 6'b111_000);
      step(1'b1, 1'b0, 6'b000_000);
    end
    step(1'b0, 1'b0, 6'b000_000);

    // 4: both requests from IDLE
`ifdef HAZARD_EN
    step(1'b1, 1'b1, 6'b111_111);
    step(1'b1, 1'b1, 6'b000_000);
    step(1'b1, 1'b1, 6'b111_111);
    step(1'b1, 1'b1, 6'b000_000);
`else
    step(1'b1, 1'b1, 6'b100_000);
    step(1'b1, 1'b1, 6'b110_000);
    step(1'b1, 1'b1, 6'b111_000);
    step(1'b1, 1'b1, 6'b000_000);
`endif
    step(1'b0, 1'b0, 6'b000_000);

    // 5: left raised during RB; right sweep finishes, then left sweep
    step(1'b0, 1'b1, 6'b000_100);
    step(1'b0, 1'b0, 6'b000_110);
    step(1'b1, 1'b0, 6'b000_111);
    step(1'b1, 1'b0, 6'b000_000);
    step(1'b1, 1'b0, 6'b100_000);
    step(1'b0, 1'b0, 6'b110_000);
    step(1'b0, 1'b0, 6'b111_000);
    step(1'b0, 1'b0, 6'b000_000);

    // 6: reset pulse between edges while in LB
    step(1'b1, 1'b0, 6'b100_000);
    step(1'b0, 1'b0, 6'b110_000);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_sweep", step_no, lamps_now(), 6'b000_000);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 6'b100_000);
    step(1'b0, 1'b0, 6'b110_000);
    step(1'b0, 1'b0, 6'b111_000);
    step(1'b0, 1'b0, 6'b000_000);
    step(1'b0, 1'b0, 6'b000_000);

    @(posedge clk);
    #2;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
